pipeline_latewb: RTL and testbench

Late writeback stage that merges results from the late ALU (shift unit, results registered one cycle after issue) and the memory load path into the single register-file write port. Sits directly downstream of the late ALU, absorbs same-cycle collisions in a small in-order write queue, and back-pressures issue when the queue nears full. Also answers operand-forwarding lookups against writes that are accepted but not yet retired.

---
 rtl/pipeline_latewb.sv | 174 +++++++++++++++++
 tb/tb_pipeline_latewb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_latewb.sv
// Late writeback stage: merges late-ALU and load results into the single
// register-file write port through a small in-order queue with forwarding.
module pipeline_latewb #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        stall_out,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  fwd_rs_addr,
  input  logic [4:0]  fwd_rt_addr,
  output logic        fwd_rs_hit,
  output logic        fwd_rt_hit,
  output logic [31:0] fwd_rs_data,
  output logic [31:0] fwd_rt_data,
  output logic        overflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    q_rd_r   [DEPTH];
  logic [31:0]   q_data_r [DEPTH];
  logic [PW-1:0] head_r, tail_r;
  logic [CW-1:0] count_r;
  logic          rf_we_r, overflow_r;
  logic [4:0]    rf_waddr_r;
  logic [31:0]   rf_wdata_r;

  logic          mem_acc_s, alu_acc_s, first_v_s, second_v_s, pop_s;
  logic [4:0]    first_rd_s;
  logic [31:0]   first_data_s;
  logic          wr_we_s;
  logic [4:0]    wr_addr_s;
  logic [31:0]   wr_data_s;
  logic          push0_v_s, push1_v_s, push0_ok_s, push1_ok_s, drop_s;
  logic [4:0]    push0_rd_s;
  logic [31:0]   push0_data_s;
  logic [CW-1:0] free_s, count_next_s;
  logic [PW-1:0] tail1_s, tail_next_s, head_next_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PW'(DEPTH - 1)) r = {PW{1'b0}};
    else                     r = p + PW'(1);
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int off);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(off);
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  // Walk oldest to youngest so the youngest match overwrites older ones;
  // the rf_* register is older than every queued entry.
  function automatic logic [32:0] fwd_search(input logic [4:0] addr);
    logic [32:0]   r;
    logic [PW-1:0] idx;
    r = {1'b0, 32'h0000_0000};
    if (rf_we_r && (rf_waddr_r == addr)) r = {1'b1, rf_wdata_r};
    for (int i = 0; i < DEPTH; i++) begin
      idx = ptr_add(head_r, i);
      if ((CW'(i) < count_r) && (q_rd_r[idx] == addr)) r = {1'b1, q_data_r[idx]};
    end
    if (addr == 5'd0) r = {1'b0, 32'h0000_0000};
    return r;
  endfunction

  // Accept/route decision: queue head has priority, else bypass the oldest input.
  always_comb begin
    mem_acc_s    = mem_valid && (mem_rd != 5'd0);
    alu_acc_s    = alu_valid && (alu_rd != 5'd0);
    first_v_s    = mem_acc_s || alu_acc_s;
    first_rd_s   = mem_acc_s ? mem_rd : alu_rd;
    first_data_s = mem_acc_s ? mem_data : alu_data;
    second_v_s   = mem_acc_s && alu_acc_s;
    pop_s        = (count_r != {CW{1'b0}});

    wr_we_s      = 1'b0;
    wr_addr_s    = rf_waddr_r;
    wr_data_s    = rf_wdata_r;
    push0_v_s    = 1'b0;
    push0_rd_s   = first_rd_s;
    push0_data_s = first_data_s;
    push1_v_s    = 1'b0;

    if (pop_s) begin
      wr_we_s   = 1'b1;
      wr_addr_s = q_rd_r[head_r];
      wr_data_s = q_data_r[head_r];
      push0_v_s = first_v_s;
      push1_v_s = second_v_s;
    end else if (first_v_s) begin
      wr_we_s      = 1'b1;
      wr_addr_s    = first_rd_s;
      wr_data_s    = first_data_s;
      push0_v_s    = second_v_s;
      push0_rd_s   = alu_rd;
      push0_data_s = alu_data;
    end else begin
      wr_we_s = 1'b0;
    end

    // The pop frees its slot before this cycle's pushes claim space.
    free_s     = CW'(DEPTH) - count_r + CW'(pop_s);
    push0_ok_s = push0_v_s && (free_s >= CW'(1));
    push1_ok_s = push1_v_s && (free_s >= CW'(2));
    drop_s     = (push0_v_s && !push0_ok_s) || (push1_v_s && !push1_ok_s);

    tail1_s = ptr_inc(tail_r);
    case ({push1_ok_s, push0_ok_s})
      2'b11:   tail_next_s = ptr_inc(tail1_s);
      2'b01:   tail_next_s = tail1_s;
      default: tail_next_s = tail_r;
    endcase
    head_next_s  = pop_s ? ptr_inc(head_r) : head_r;
    count_next_s = count_r - CW'(pop_s) + CW'(push0_ok_s) + CW'(push1_ok_s);
  end

  // Control state, retire register and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      rf_we_r    <= 1'b0;
      rf_waddr_r <= 5'd0;
      rf_wdata_r <= 32'h0000_0000;
      overflow_r <= 1'b0;
    end else begin
      head_r     <= head_next_s;
      tail_r     <= tail_next_s;
      count_r    <= count_next_s;
      rf_we_r    <= wr_we_s;
      rf_waddr_r <= wr_addr_s;
      rf_wdata_r <= wr_data_s;
      overflow_r <= overflow_r || drop_s;
    end
  end

  // Queue payload storage; validity is tracked solely by count/head.
  always_ff @(posedge clk) begin
    if (push0_ok_s) begin
      q_rd_r[tail_r]   <= push0_rd_s;
      q_data_r[tail_r] <= push0_data_s;
    end
    if (push1_ok_s) begin
      q_rd_r[tail1_s]   <= alu_rd;
      q_data_r[tail1_s] <= alu_data;
    end
  end

  // Forwarding lookups and back-pressure decode.
  always_comb begin
    {fwd_rs_hit, fwd_rs_data} = fwd_search(fwd_rs_addr);
    {fwd_rt_hit, fwd_rt_data} = fwd_search(fwd_rt_addr);
    stall_out = (count_r >= CW'(DEPTH - 2));
  end

  assign rf_we    = rf_we_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_pipeline_latewb.sv
// Self-checking bench for pipeline_latewb: directed vector table, hand-written
// overflow/reset sequences, then random traffic against a queue-based model.
module tb_pipeline_latewb;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        stall_out, rf_we, overflow;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_rs_addr, fwd_rt_addr;
  logic        fwd_rs_hit, fwd_rt_hit;
  logic [31:0] fwd_rs_data, fwd_rt_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_latewb #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .stall_out(stall_out),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_rs_addr(fwd_rs_addr), .fwd_rt_addr(fwd_rt_addr),
    .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
    .overflow(overflow)
  );

  typedef struct {
    logic        mv; logic [4:0] mrd; logic [31:0] md;
    logic        av; logic [4:0] ard; logic [31:0] ad;
    logic [4:0]  rsa;
    logic        we; logic [4:0] waddr; logic [31:0] wdata;
    logic        stall; logic hit; logic [31:0] hdata;
  } vec_t;

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;

  vec_t  tbl [12];
  ent_t  mq[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad);
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
  endtask

  // Reference: accepted inputs in age order; head retires first, else oldest input bypasses.
  task automatic model_step(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                            input logic av, input logic [4:0] ard, input logic [31:0] ad);
    ent_t inq[$];
    ent_t e;
    if (mv && mrd != 5'd0) inq.push_back('{mrd, md});
    if (av && ard != 5'd0) inq.push_back('{ard, ad});
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = 1'b1; m_addr = e.rd; m_data = e.data;
    end else if (inq.size() > 0) begin
      e = inq.pop_front();
      m_we = 1'b1; m_addr = e.rd; m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    foreach (inq[k]) begin
      if (mq.size() < DEPTH) mq.push_back(inq[k]);
      else m_ovf = 1'b1;
    end
  endtask

  function automatic logic [32:0] m_fwd(input logic [4:0] addr);
    if (addr == 5'd0) return 33'd0;
    for (int k = mq.size() - 1; k >= 0; k--)
      if (mq[k].rd == addr) return {1'b1, mq[k].data};
    if (m_we && m_addr == addr) return {1'b1, m_data};
    return 33'd0;
  endfunction

  initial begin
    logic [32:0] exp_f;
    logic [4:0]  d_addr [4];
    logic [31:0] d_data [4];

    // mv mrd md | av ard ad | rsa | we waddr wdata | stall hit hdata
    tbl[0]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'h8000_0000, 5'd5, 1'b1, 5'd5, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,         5'd5, 1'b0, 5'd5, 32'h8000_0000, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 5'd3, 32'h11,   1'b1, 5'd3, 32'h22,        5'd3, 1'b1, 5'd3, 32'h11,        1'b0, 1'b1, 32'h22};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,         5'd3, 1'b1, 5'd3, 32'h22,        1'b0, 1'b1, 32'h22};
    tbl[4]  = '{1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF,      5'd0, 1'b0, 5'd3, 32'h22,        1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 5'd1, 32'hA1,   1'b1, 5'd2, 32'hB1,        5'd2, 1'b1, 5'd1, 32'hA1,        1'b0, 1'b1, 32'hB1};
    tbl[6]  = '{1'b1, 5'd3, 32'hA2,   1'b1, 5'd4, 32'hB2,        5'd2, 1'b1, 5'd2, 32'hB1,        1'b1, 1'b1, 32'hB1};
    tbl[7]  = '{1'b1, 5'd5, 32'hA3,   1'b1, 5'd6, 32'hB3,        5'd4, 1'b1, 5'd3, 32'hA2,        1'b1, 1'b1, 32'hB2};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,         5'd6, 1'b1, 5'd4, 32'hB2,        1'b1, 1'b1, 32'hB3};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,         5'd5, 1'b1, 5'd5, 32'hA3,        1'b0, 1'b1, 32'hA3};
    tbl[10] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,         5'd6, 1'b1, 5'd6, 32'hB3,        1'b0, 1'b1, 32'hB3};
    tbl[11] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,         5'd6, 1'b0, 5'd6, 32'hB3,        1'b0, 1'b0, 32'h0};

    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    fwd_rs_addr = 5'd0; fwd_rt_addr = 5'd0;
    repeat (2) @(negedge clk);
    chk("reset_we",    32'(rf_we), 32'd0);
    chk("reset_waddr", 32'(rf_waddr), 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_stall", 32'(stall_out), 32'd0);
    chk("reset_ovf",   32'(overflow), 32'd0);
    chk("reset_rshit", 32'(fwd_rs_hit), 32'd0);
    rst = 1'b0;

    // Directed vectors: single write, collision, rd=0, dual-valid fill and drain.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].mv, tbl[i].mrd, tbl[i].md, tbl[i].av, tbl[i].ard, tbl[i].ad);
      fwd_rs_addr = tbl[i].rsa;
      @(negedge clk);
      chk($sformatf("vec%0d_we", i),    32'(rf_we), 32'(tbl[i].we));
      chk($sformatf("vec%0d_waddr", i), 32'(rf_waddr), 32'(tbl[i].waddr));
      chk($sformatf("vec%0d_wdata", i), rf_wdata, tbl[i].wdata);
      chk($sformatf("vec%0d_stall", i), 32'(stall_out), 32'(tbl[i].stall));
      chk($sformatf("vec%0d_hit", i),   32'(fwd_rs_hit), 32'(tbl[i].hit));
      chk($sformatf("vec%0d_hdata", i), fwd_rs_data, tbl[i].hdata);
      chk($sformatf("vec%0d_ovf", i),   32'(overflow), 32'd0);
    end

    // Overflow: dual-valid ignoring stall; fifth cycle drops the alu write.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 5'd7, 32'h100 + 32'(i), 1'b1, 5'd8, 32'h200 + 32'(i));
      @(negedge clk);
      if (i == 4) chk("ovf_before", 32'(overflow), 32'd0);
    end
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_stall", 32'(stall_out), 32'd1);
    d_addr[0] = 5'd8; d_data[0] = 32'h203;
    d_addr[1] = 5'd7; d_data[1] = 32'h104;
    d_addr[2] = 5'd8; d_data[2] = 32'h204;
    d_addr[3] = 5'd7; d_data[3] = 32'h105;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_we", i),    32'(rf_we), 32'd1);
      chk($sformatf("drain%0d_waddr", i), 32'(rf_waddr), 32'(d_addr[i]));
      chk($sformatf("drain%0d_wdata", i), rf_wdata, d_data[i]);
      chk($sformatf("drain%0d_ovf", i),   32'(overflow), 32'd1);
    end
    @(negedge clk);
    chk("drained_we", 32'(rf_we), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Async reset with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd10, 32'h300 + 32'(i), 1'b1, 5'd11, 32'h400 + 32'(i));
      @(negedge clk);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    fwd_rs_addr = 5'd11;
    #1;
    chk("prerst_hit", 32'(fwd_rs_hit), 32'd1);
    chk("prerst_stall", 32'(stall_out), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_we",    32'(rf_we), 32'd0);
    chk("arst_waddr", 32'(rf_waddr), 32'd0);
    chk("arst_wdata", rf_wdata, 32'd0);
    chk("arst_stall", 32'(stall_out), 32'd0);
    chk("arst_ovf",   32'(overflow), 32'd0);
    chk("arst_hit",   32'(fwd_rs_hit), 32'd0);
    chk("arst_hdata", fwd_rs_data, 32'd0);
    @(negedge clk);
    chk("inrst_we", 32'(rf_we), 32'd0);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    chk("postrst_we",    32'(rf_we), 32'd1);
    chk("postrst_waddr", 32'(rf_waddr), 32'd9);
    chk("postrst_wdata", rf_wdata, 32'h99);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("postrst_idle_we", 32'(rf_we), 32'd0);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_we = 1'b0; m_addr = 5'd0; m_data = 32'h0; m_ovf = 1'b0;
    for (int n = 0; n < 800; n++) begin
      logic mv, av, honor;
      logic [4:0] mrd, ard;
      logic [31:0] md, ad;
      honor = ($urandom_range(0, 3) != 0);
      mv  = ($urandom_range(0, 9) < 6);
      av  = ($urandom_range(0, 9) < 6);
      if (honor && mq.size() >= DEPTH - 2) begin mv = 1'b0; av = 1'b0; end
      mrd = 5'($urandom_range(0, 7)); ard = 5'($urandom_range(0, 7));
      md  = $urandom; ad = $urandom;
      drive(mv, mrd, md, av, ard, ad);
      fwd_rs_addr = 5'($urandom_range(0, 7));
      fwd_rt_addr = 5'($urandom_range(0, 7));
      model_step(mv, mrd, md, av, ard, ad);
      @(negedge clk);
      chk("rnd_we",    32'(rf_we), 32'(m_we));
      chk("rnd_waddr", 32'(rf_waddr), 32'(m_addr));
      chk("rnd_wdata", rf_wdata, m_data);
      chk("rnd_stall", 32'(stall_out), 32'(mq.size() >= DEPTH - 2));
      chk("rnd_ovf",   32'(overflow), 32'(m_ovf));
      exp_f = m_fwd(fwd_rs_addr);
      chk("rnd_rs_hit",  32'(fwd_rs_hit), 32'(exp_f[32]));
      chk("rnd_rs_data", fwd_rs_data, exp_f[31:0]);
      exp_f = m_fwd(fwd_rt_addr);
      chk("rnd_rt_hit",  32'(fwd_rt_hit), 32'(exp_f[32]));
      chk("rnd_rt_data", fwd_rt_data, exp_f[31:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
